// File: rtl/wb_stage_if.sv
// MEM -> WB pipeline bus: valid/allowin handshake plus the instruction payload.
interface wb_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  mem_valid;
  logic                  wb_allowin;
  logic [31:0]           mem_pc;
  logic [ADDR_WIDTH-1:0] mem_dest;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_res;
  logic [2:0]            mem_load_op;
  logic [DATA_WIDTH-1:0] mem_rt_val;

  modport master (
    output mem_valid, mem_pc, mem_dest, mem_wen, mem_res, mem_load_op, mem_rt_val,
    input  wb_allowin
  );

  modport slave (
    input  mem_valid, mem_pc, mem_dest, mem_wen, mem_res, mem_load_op, mem_rt_val,
    output wb_allowin
  );
endinterface

// File: rtl/wb_stage.sv
// MIPS writeback stage: MEM/WB register, load alignment (incl. lwl/lwr), RF write port, bypass.
// Optional trace ports and retire counter are enabled by defining WB_TRACE_EN.
module wb_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_stage_if.slave             mem_if,
  input  logic [DATA_WIDTH-1:0] dram_rdata,
  input  logic                  wb_hold,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_dest,
  output logic [DATA_WIDTH-1:0] fwd_data
`ifdef WB_TRACE_EN
  ,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [ADDR_WIDTH-1:0] debug_wb_rf_wnum,
  output logic [DATA_WIDTH-1:0] debug_wb_rf_wdata,
  output logic [31:0]           retire_cnt
`endif
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [2:0] LD_LWL  = 3'd6;
  localparam logic [2:0] LD_LWR  = 3'd7;

  function automatic logic [DATA_WIDTH-1:0] sext8(input logic signed [7:0] v);
    return {{(DATA_WIDTH-8){v[7]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext8(input logic [7:0] v);
    return {{(DATA_WIDTH-8){1'b0}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext16(input logic signed [15:0] v);
    return {{(DATA_WIDTH-16){v[15]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext16(input logic [15:0] v);
    return {{(DATA_WIDTH-16){1'b0}}, v};
  endfunction

  // lwl fills from the most-significant end, keeping the low bytes of rt.
  function automatic logic [DATA_WIDTH-1:0] merge_lwl(input logic [1:0] a,
                                                      input logic [DATA_WIDTH-1:0] w,
                                                      input logic [DATA_WIDTH-1:0] rt);
    case (a)
      2'd0:    return {w[7:0],  rt[23:0]};
      2'd1:    return {w[15:0], rt[15:0]};
      2'd2:    return {w[23:0], rt[7:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_lwr(input logic [1:0] a,
                                                      input logic [DATA_WIDTH-1:0] w,
                                                      input logic [DATA_WIDTH-1:0] rt);
    case (a)
      2'd1:    return {rt[31:24], w[31:8]};
      2'd2:    return {rt[31:16], w[31:16]};
      2'd3:    return {rt[31:8],  w[31:24]};
      default: return w;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_align(input logic [2:0]            op,
                                                       input logic [DATA_WIDTH-1:0] res,
                                                       input logic [DATA_WIDTH-1:0] w,
                                                       input logic [DATA_WIDTH-1:0] rt);
    logic [1:0]  a;
    logic [7:0]  b;
    logic [15:0] h;
    a = res[1:0];
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      LD_LB:   return sext8(b);
      LD_LBU:  return zext8(b);
      LD_LH:   return sext16(h);
      LD_LHU:  return zext16(h);
      LD_LW:   return w;
      LD_LWL:  return merge_lwl(a, w, rt);
      LD_LWR:  return merge_lwr(a, w, rt);
      LD_NONE: return res;
      default: return res;
    endcase
  endfunction

  logic                  wb_valid_q, wb_valid_d;
  logic [31:0]           pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] dest_q, dest_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic [2:0]            load_op_q, load_op_d;
  logic [DATA_WIDTH-1:0] rt_val_q, rt_val_d;

  logic                  ready_go;
  logic                  allowin;
  logic                  dest_live;
  logic [DATA_WIDTH-1:0] final_data;

  assign ready_go          = !wb_hold;
  assign allowin           = !wb_valid_q || ready_go;
  assign mem_if.wb_allowin = allowin;

  always_comb begin
    wb_valid_d = wb_valid_q;
    pc_d       = pc_q;
    dest_d     = dest_q;
    wen_d      = wen_q;
    res_d      = res_q;
    load_op_d  = load_op_q;
    rt_val_d   = rt_val_q;
    if (allowin) begin
      wb_valid_d = mem_if.mem_valid;
      if (mem_if.mem_valid) begin
        pc_d      = mem_if.mem_pc;
        dest_d    = mem_if.mem_dest;
        wen_d     = mem_if.mem_wen;
        res_d     = mem_if.mem_res;
        load_op_d = mem_if.mem_load_op;
        rt_val_d  = mem_if.mem_rt_val;
      end
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      pc_q       <= '0;
      dest_q     <= '0;
      wen_q      <= 1'b0;
      res_q      <= '0;
      load_op_q  <= '0;
      rt_val_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      pc_q       <= pc_d;
      dest_q     <= dest_d;
      wen_q      <= wen_d;
      res_q      <= res_d;
      load_op_q  <= load_op_d;
      rt_val_q   <= rt_val_d;
    end
  end

  assign final_data = load_align(load_op_q, res_q, dram_rdata, rt_val_q);
  assign dest_live  = wb_valid_q && wen_q && (dest_q != '0);

  // The bypass ignores wb_hold so decode can see a stalled instruction's value.
  assign rf_wen    = dest_live && ready_go;
  assign rf_waddr  = wb_valid_q ? dest_q : '0;
  assign rf_wdata  = wb_valid_q ? final_data : '0;
  assign fwd_valid = dest_live;
  assign fwd_dest  = rf_waddr;
  assign fwd_data  = rf_wdata;

`ifdef WB_TRACE_EN
  logic [31:0] retire_cnt_q, retire_cnt_d;

  assign retire_cnt_d = (wb_valid_q && ready_go) ? retire_cnt_q + 32'd1 : retire_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt        = retire_cnt_q;
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_wen   = {4{rf_wen}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  // The PC is only consumed by the trace outputs.
  logic pc_unused;
  assign pc_unused = ^pc_q;
`endif

endmodule
